decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined RV32I decode stage sitting between fetch and execute: accepts one 32-bit instruction per valid/ready handshake and decodes it into the ALU control word (`op`, `sign`, `b_add_one`, `b_negate`), operand-source selects, register indices and sign-extended immediate. Results are registered and presented to execute through a 2-entry skid buffer, so full throughput is sustained under back-pressure without a combinational ready path.

## Interface
- `WIDTH`, 32, datapath/immediate/PC width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous; discards all held and incoming instructions this cycle
- `in_valid`  in  1  fetch presents instruction
- `in_ready`  out  1  decode can accept; registered
- `in_instr`  in  32  instruction word
- `in_pc`  in  WIDTH  instruction address
- `out_valid`  out  1  decoded word valid
- `out_ready`  in  1  execute accepts
- `out_alu_op`  out  3  ALU operation
- `out_alu_sign`, `out_alu_b_add_one`, `out_alu_b_negate`  out  1 each  ALU modifiers
- `out_a_src`  out  2  A operand: RS1 / PC / ZERO
- `out_b_src`  out  1  B operand: RS2 / IMM
- `out_imm`  out  WIDTH  sign-extended immediate
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  register indices
- `out_class`  out  3  ALU / LOAD / STORE / BRANCH / JAL / JALR / UPPER
- `out_illegal`  out  1  unsupported encoding
- `out_pc`  out  WIDTH  pass-through PC

## Operation
- Transfer on `valid && ready`, each side independently.
- Decode (combinational, before the buffer):
  - OP (0110011): `alu_op=funct3`, `b_src=RS2`; funct7=0100000 with funct3=000 → `b_negate=b_add_one=1` (SUB); with funct3=101 → `sign=1` (SRA).
  - OP-IMM (0010011): `alu_op=funct3`, `b_src=IMM`; funct3=101 → `sign=instr[30]`; never negates.
  - BRANCH: BEQ/BNE → op 000, negate+add_one (zero flag result); BLT/BGE → op 010; BLTU/BGEU → op 011; `b_src=RS2`.
  - LOAD/STORE/JALR → op 000, A=RS1, B=IMM; AUIPC/JAL → A=PC, B=IMM; LUI → A=ZERO, B=IMM.
  - Immediates per I/S/B/U/J format, bit 31 sign-extended to WIDTH.
  - Illegal: unknown opcode; OP funct7 ∉ {0000000, 0100000}; 0100000 on funct3 ∉ {000,101}; OP-IMM shifts with instr[31:25] ∉ {0000000, 0100000} (SLLI: only 0000000). Illegal words still flow, `out_illegal=1`, other fields 0.
- Skid buffer: main + skid entry. `in_ready` = skid entry empty. Output stalled + input accepted → word lands in skid; on drain, skid moves to main next cycle. Order strictly preserved.
- `flush`: both entries invalidated, same-cycle input dropped; `in_ready=1` next cycle.

## Timing
- Latency 1 cycle: accepted at edge N → `out_valid` after edge N, same cycle `out_ready` may consume.
- Throughput 1/cycle with `out_ready=1`.
- Reset (any time, mid-transfer included): `out_valid=0`, `in_ready=1`, all payload outputs 0, both entries empty; in-flight words lost.
- `out_valid` stable and payload held until accepted.
- Buffer states: EMPTY → ONE (accept) → TWO (accept while stalled, `in_ready` falls next edge) → ONE (drain) → EMPTY. Simultaneous accept+drain in ONE stays ONE. `flush` beats everything except reset.

## Structure
- Package `decode_pkg`: opcode constants, `alu_op_e` (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND), `a_src_e`, `b_src_e`, `instr_class_e`, packed `decoded_t` payload struct.
- Sub-module `skid_buffer` (parameterized payload width, valid/ready both sides, `flush`); decode logic in `decode_stage` itself.

## Test plan
- ADD x3,x1,x2 (0x002081B3) → op 000, negate=0, add_one=0, rs1=1, rs2=2, rd=3, b_src=RS2, one cycle later.
- SUB x3,x1,x2 (0x402081B3) → op 000, negate=1, add_one=1; SRAI x5,x6,3 (0x40335293) → op 101, sign=1, imm=0x403, b_src=IMM.
- ADDI x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF; BLTU → op 011; LUI → a_src=ZERO; opcode 0x7F → illegal=1.
- Stream 8 words, `out_ready` low 3 cycles → `in_ready` falls after 2 held, all 8 delivered in order, no duplicates.
- `flush` with both entries full → `out_valid=0` next cycle, `in_ready=1`, flushed words never appear.
- `rst_n` low mid-stream (async) → outputs zero immediately; stream resumes cleanly after release.

Source files
------------

// File: rtl/decode_pkg.sv
// RV32I decode definitions: opcodes, ALU control encodings, operand selects, payload struct.
// No logic latency (types and constants only).
// Not applicable: no flow control lives here.
package decode_pkg;

    // Major opcodes (instr[6:0]) handled by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } a_src_e;

    typedef enum logic {
        B_RS2 = 1'b0,
        B_IMM = 1'b1
    } b_src_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_UPPER  = 3'd6
    } instr_class_e;

    // Control part of the decoded word; immediate and PC travel alongside at WIDTH bits
    typedef struct packed {
        alu_op_e      alu_op;
        logic         alu_sign;
        logic         b_add_one;
        logic         b_negate;
        a_src_e       a_src;
        b_src_e       b_src;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        instr_class_e cls;
        logic         illegal;
    } decoded_t;

    // OP-IMM shift immediates: SLLI needs a zero upper field, SRLI/SRAI may use the alternate
    function automatic logic shift_imm_legal(input logic [2:0] funct3, input logic [6:0] funct7);
        logic ok;
        ok = 1'b1;
        if (funct3 == 3'b001) begin
            ok = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
            ok = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        end
        return ok;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline register (main + skid) with synchronous flush.
// Latency 1 cycle from input handshake to out_valid; full throughput when drained.
// in_ready is registered (low only while skid entry is occupied); order strictly preserved.
module skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    buf_state_e   state;
    buf_state_e   state_nxt;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;
    logic         accept;
    logic         drain;

    // Both handshake flags come straight from the state register
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // Next occupancy and which entry loads from where; flush overrides everything
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Entry storage; cleared on reset so payload outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode: instruction word -> ALU control, operand selects, registers, immediate.
// Latency 1 cycle (combinational decode into a registered 2-entry skid buffer).
// Back-pressure absorbed by the skid entry; in_ready is registered, never combinational.
module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_alu_op,
    output logic             out_alu_sign,
    output logic             out_alu_b_add_one,
    output logic             out_alu_b_negate,
    output logic [1:0]       out_a_src,
    output logic             out_b_src,
    output logic [WIDTH-1:0] out_imm,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_class,
    output logic             out_illegal,
    output logic [WIDTH-1:0] out_pc
);

    localparam int PW = $bits(decoded_t) + 2 * WIDTH;

    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1_f;
    logic [4:0]       rs2_f;
    logic [4:0]       rd_f;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_b;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] imm_j;
    decoded_t         dec;
    logic [WIDTH-1:0] imm;
    logic [PW-1:0]    pay_in;
    logic [PW-1:0]    pay_out;
    decoded_t         odec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1_f  = in_instr[19:15];
    assign rs2_f  = in_instr[24:20];
    assign rd_f   = in_instr[11:7];

    // All immediate formats, sign-extended from instr[31]
    assign imm_i = WIDTH'($signed(in_instr[31:20]));
    assign imm_s = WIDTH'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = WIDTH'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign imm_u = WIDTH'($signed({in_instr[31:12], 12'h000}));
    assign imm_j = WIDTH'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

    // Opcode decode; unused register indices stay zero and illegal words carry only the flag (plus PC)
    always_comb begin
        dec = '0;
        imm = '0;
        case (opcode)
            OPC_OP: begin
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
                    dec.cls    = CLS_ALU;
                    dec.alu_op = alu_op_e'(funct3);
                    dec.a_src  = A_RS1;
                    dec.b_src  = B_RS2;
                    dec.rs1    = rs1_f;
                    dec.rs2    = rs2_f;
                    dec.rd     = rd_f;
                    if (funct7 == F7_ALT) begin
                        if (funct3 == 3'b000) begin
                            dec.b_negate  = 1'b1;
                            dec.b_add_one = 1'b1;
                        end else begin
                            dec.alu_sign = 1'b1;
                        end
                    end
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (shift_imm_legal(funct3, funct7)) begin
                    dec.cls      = CLS_ALU;
                    dec.alu_op   = alu_op_e'(funct3);
                    dec.alu_sign = (funct3 == 3'b101) && in_instr[30];
                    dec.a_src    = A_RS1;
                    dec.b_src    = B_IMM;
                    dec.rs1      = rs1_f;
                    dec.rd       = rd_f;
                    imm          = imm_i;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                dec.cls   = CLS_LOAD;
                dec.a_src = A_RS1;
                dec.b_src = B_IMM;
                dec.rs1   = rs1_f;
                dec.rd    = rd_f;
                imm       = imm_i;
            end
            OPC_STORE: begin
                dec.cls   = CLS_STORE;
                dec.a_src = A_RS1;
                dec.b_src = B_IMM;
                dec.rs1   = rs1_f;
                dec.rs2   = rs2_f;
                imm       = imm_s;
            end
            OPC_BRANCH: begin
                dec.cls   = CLS_BRANCH;
                dec.a_src = A_RS1;
                dec.b_src = B_RS2;
                dec.rs1   = rs1_f;
                dec.rs2   = rs2_f;
                imm       = imm_b;
                // Equality compares subtract and test for zero; ordered compares use SLT/SLTU
                case (funct3[2:1])
                    2'b00: begin
                        dec.alu_op    = ALU_ADD;
                        dec.b_negate  = 1'b1;
                        dec.b_add_one = 1'b1;
                    end
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: dec.alu_op = ALU_ADD;
                endcase
            end
            OPC_JAL: begin
                dec.cls   = CLS_JAL;
                dec.a_src = A_PC;
                dec.b_src = B_IMM;
                dec.rd    = rd_f;
                imm       = imm_j;
            end
            OPC_JALR: begin
                dec.cls   = CLS_JALR;
                dec.a_src = A_RS1;
                dec.b_src = B_IMM;
                dec.rs1   = rs1_f;
                dec.rd    = rd_f;
                imm       = imm_i;
            end
            OPC_LUI: begin
                dec.cls   = CLS_UPPER;
                dec.a_src = A_ZERO;
                dec.b_src = B_IMM;
                dec.rd    = rd_f;
                imm       = imm_u;
            end
            OPC_AUIPC: begin
                dec.cls   = CLS_UPPER;
                dec.a_src = A_PC;
                dec.b_src = B_IMM;
                dec.rd    = rd_f;
                imm       = imm_u;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign pay_in = {dec, imm, in_pc};

    skid_buffer #(
        .W(PW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign {odec, out_imm, out_pc} = pay_out;
    assign out_alu_op        = odec.alu_op;
    assign out_alu_sign      = odec.alu_sign;
    assign out_alu_b_add_one = odec.b_add_one;
    assign out_alu_b_negate  = odec.b_negate;
    assign out_a_src         = odec.a_src;
    assign out_b_src         = odec.b_src;
    assign out_rs1           = odec.rs1;
    assign out_rs2           = odec.rs2;
    assign out_rd            = odec.rd;
    assign out_class         = odec.cls;
    assign out_illegal       = odec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction words, queue-based reference model.
// Compare process runs on every falling edge; literal checks pin the model.
// Covers stall/skid, flush and asynchronous reset mid-stream.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic        sign;
        logic        add1;
        logic        neg;
        logic [1:0]  a;
        logic        b;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  cls;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [2:0]  out_alu_op;
    logic        out_alu_sign;
    logic        out_alu_b_add_one;
    logic        out_alu_b_negate;
    logic [1:0]  out_a_src;
    logic        out_b_src;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_class;
    logic        out_illegal;
    logic [31:0] out_pc;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_deliv = 0;
    exp_t q[$];
    logic [31:0] tbl[16];

    decode_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_alu_sign(out_alu_sign),
        .out_alu_b_add_one(out_alu_b_add_one), .out_alu_b_negate(out_alu_b_negate),
        .out_a_src(out_a_src), .out_b_src(out_b_src), .out_imm(out_imm),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_class(out_class), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference decode written per instruction family from the ISA definition
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
        e = '0;
        e.pc = pc;
        opc = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        i_imm = {{20{w[31]}}, w[31:20]};
        s_imm = {{20{w[31]}}, w[31:25], w[11:7]};
        b_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        u_imm = {w[31:12], 12'h000};
        j_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (opc == 7'h33) begin
            if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
                e.op = f3; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
                e.b = 1'b0; e.cls = CLS_ALU;
                e.neg = (f7 == 7'h20 && f3 == 3'd0);
                e.add1 = e.neg;
                e.sign = (f7 == 7'h20 && f3 == 3'd5);
            end else e.ill = 1'b1;
        end else if (opc == 7'h13) begin
            if ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
                e.ill = 1'b1;
            else begin
                e.op = f3; e.rs1 = w[19:15]; e.rd = w[11:7]; e.b = 1'b1; e.imm = i_imm;
                e.cls = CLS_ALU; e.sign = (f3 == 3'd5) && w[30];
            end
        end else if (opc == 7'h03) begin
            e.cls = CLS_LOAD; e.b = 1'b1; e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = i_imm;
        end else if (opc == 7'h23) begin
            e.cls = CLS_STORE; e.b = 1'b1; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = s_imm;
        end else if (opc == 7'h63) begin
            e.cls = CLS_BRANCH; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = b_imm;
            if (f3 == 3'd0 || f3 == 3'd1) begin e.neg = 1'b1; e.add1 = 1'b1; end
            else if (f3 == 3'd4 || f3 == 3'd5) e.op = 3'd2;
            else if (f3 == 3'd6 || f3 == 3'd7) e.op = 3'd3;
        end else if (opc == 7'h6F) begin
            e.cls = CLS_JAL; e.a = 2'd1; e.b = 1'b1; e.rd = w[11:7]; e.imm = j_imm;
        end else if (opc == 7'h67) begin
            e.cls = CLS_JALR; e.b = 1'b1; e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = i_imm;
        end else if (opc == 7'h37) begin
            e.cls = CLS_UPPER; e.a = 2'd2; e.b = 1'b1; e.rd = w[11:7]; e.imm = u_imm;
        end else if (opc == 7'h17) begin
            e.cls = CLS_UPPER; e.a = 2'd1; e.b = 1'b1; e.rd = w[11:7]; e.imm = u_imm;
        end else e.ill = 1'b1;
        return e;
    endfunction

    function automatic exp_t dut_word();
        return exp_t'({out_alu_op, out_alu_sign, out_alu_b_add_one, out_alu_b_negate,
                       out_a_src, out_b_src, out_imm, out_rs1, out_rs2, out_rd,
                       out_class, out_illegal, out_pc});
    endfunction

    // Compare process: occupancy, head payload (also while stalled) and ordering
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", 128'(out_valid), 128'd0);
            chk("rst_in_ready", 128'(in_ready), 128'd1);
            chk("rst_payload", 128'(dut_word()), 128'd0);
        end else begin
            chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
            chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", 128'(dut_word()), 128'd0);
                end else begin
                    chk($sformatf("payload_%0d", n_deliv), 128'(dut_word()), 128'(q[0]));
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    n_deliv++;
                end
                if (in_valid && in_ready) q.push_back(ref_decode(in_instr, in_pc));
            end
        end
    end

    task automatic send1(input logic [31:0] w, input logic [31:0] pc);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = w;
        in_pc = pc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("send1_valid", 128'(out_valid), 128'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
    endtask

    task automatic run_stream(input int n, input int s0, input int slen, input int off,
                              output int cycles, output logic rdy2);
        int i;
        int cyc;
        logic fire;
        i = 0; cyc = 0; rdy2 = 1'bx;
        while (i < n && cyc < 200) begin
            in_valid = 1'b1;
            in_instr = tbl[(i + off) % 16];
            in_pc = 32'h1000 + 32'(off * 64) + 32'(4 * i);
            out_ready = !(cyc >= s0 && cyc < s0 + slen);
            @(negedge clk);
            fire = in_ready;
            if (cyc == 2) rdy2 = in_ready;
            @(posedge clk); #1;
            if (fire) i++;
            cyc++;
        end
        if (i < n) chk("stream_timeout", 128'(i), 128'(n));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10 && out_valid; k++) begin @(posedge clk); #1; end
        chk("stream_drained", 128'(out_valid), 128'd0);
        cycles = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic rdy2;
        int d0;
        tbl[0]  = 32'h002081B3; // add  x3,x1,x2
        tbl[1]  = 32'h402081B3; // sub  x3,x1,x2
        tbl[2]  = 32'h40335293; // srai x5,x6,3
        tbl[3]  = 32'hFFF00093; // addi x1,x0,-1
        tbl[4]  = 32'h0020E463; // bltu x1,x2,+8
        tbl[5]  = 32'h123452B7; // lui  x5,0x12345
        tbl[6]  = 32'h0000007F; // unknown opcode
        tbl[7]  = 32'h0020A423; // sw   x2,8(x1)
        tbl[8]  = 32'hFFDFF0EF; // jal  x1,-4
        tbl[9]  = 32'h00008067; // jalr x0,0(x1)
        tbl[10] = 32'h202081B3; // OP with bad funct7
        tbl[11] = 32'h40309293; // slli with alternate funct7
        tbl[12] = 32'h00001517; // auipc x10,1
        tbl[13] = 32'hFE208CE3; // beq  x1,x2,-8
        tbl[14] = 32'h009463B3; // or   x7,x8,x9
        tbl[15] = 32'hFFC12203; // lw   x4,-4(x2)

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // Single words with hand-computed fields, checked one cycle after acceptance
        send1(tbl[0], 32'h100);
        chk("add_op", 128'(out_alu_op), 128'd0);
        chk("add_neg_add1", 128'({out_alu_b_negate, out_alu_b_add_one}), 128'd0);
        chk("add_regs", 128'({out_rs1, out_rs2, out_rd}), 128'({5'd1, 5'd2, 5'd3}));
        chk("add_b_src", 128'(out_b_src), 128'd0);
        send1(tbl[1], 32'h104);
        chk("sub_op", 128'(out_alu_op), 128'd0);
        chk("sub_neg_add1", 128'({out_alu_b_negate, out_alu_b_add_one}), 128'd3);
        send1(tbl[2], 32'h108);
        chk("srai_op", 128'(out_alu_op), 128'd5);
        chk("srai_sign", 128'(out_alu_sign), 128'd1);
        chk("srai_imm", 128'(out_imm), 128'h403);
        chk("srai_b_src", 128'(out_b_src), 128'd1);
        send1(tbl[3], 32'h10C);
        chk("addi_imm", 128'(out_imm), 128'hFFFFFFFF);
        send1(tbl[4], 32'h110);
        chk("bltu_op", 128'(out_alu_op), 128'd3);
        chk("bltu_imm", 128'(out_imm), 128'd8);
        send1(tbl[5], 32'h114);
        chk("lui_a_src", 128'(out_a_src), 128'd2);
        chk("lui_imm", 128'(out_imm), 128'h12345000);
        send1(tbl[6], 32'h118);
        chk("illegal_flag", 128'(out_illegal), 128'd1);
        chk("illegal_imm", 128'(out_imm), 128'd0);
        chk("illegal_pc", 128'(out_pc), 128'h118);
        send1(tbl[8], 32'h11C);
        chk("jal_imm", 128'(out_imm), 128'hFFFFFFFC);
        idle(2);

        // Full throughput: eight words in eight cycles
        run_stream(8, 1000, 0, 8, cyc, rdy2);
        chk("throughput_cycles", 128'(cyc), 128'd8);

        // Output stalled three cycles: two words held, in_ready drops, all eight arrive in order
        d0 = n_deliv;
        run_stream(8, 0, 3, 0, cyc, rdy2);
        chk("stall_in_ready", 128'(rdy2), 128'd0);
        chk("stall_delivered", 128'(n_deliv - d0), 128'd8);

        // Flush with both entries full plus a word offered in the same cycle
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = tbl[14]; in_pc = 32'h2000;
        @(posedge clk); #1;
        in_instr = tbl[15]; in_pc = 32'h2004;
        @(posedge clk); #1;
        chk("flush_pre_in_ready", 128'(in_ready), 128'd0);
        in_instr = tbl[13]; in_pc = 32'h2008; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 128'(out_valid), 128'd0);
        chk("flush_in_ready", 128'(in_ready), 128'd1);
        out_ready = 1'b1;
        idle(2);
        send1(tbl[7], 32'h3000);
        chk("post_flush_pc", 128'(out_pc), 128'h3000);
        idle(2);

        // Asynchronous reset in the middle of a stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_instr = tbl[9 + k]; in_pc = 32'h4000 + 32'(4 * k);
            @(posedge clk); #1;
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        in_valid = 1'b1; in_instr = tbl[12]; in_pc = 32'h400C;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'd0);
        chk("arst_in_ready", 128'(in_ready), 128'd1);
        chk("arst_payload", 128'({out_imm, out_pc, out_rd}), 128'd0);
        in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        run_stream(8, 3, 2, 4, cyc, rdy2);
        idle(2);
        chk("model_queue_empty", 128'(q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
